// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes
// (aligned with ALU_Control), FSM state encoding and op-decode helpers.
package mdu_pkg;

    localparam logic [3:0] MDU_MUL  = 4'b0011;
    localparam logic [3:0] MDU_MULU = 4'b0100;
    localparam logic [3:0] MDU_DIV  = 4'b0101;
    localparam logic [3:0] MDU_DIVU = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    function automatic logic is_mdu_op(input logic [3:0] op);
        return (op == MDU_MUL) || (op == MDU_MULU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == MDU_MUL) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Two's-complement conditional negate: yields |x| at operand capture and
// re-applies the result sign at the end of an operation.
module mdu_sign_fix #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] val_i,
    input  logic              neg_i,
    output logic [DATA_W-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + DATA_W'(1)) : val_i;

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with HI/LO and start/busy/done handshake.
// Optional MTHI/MTLO write port enabled by defining MDU_HILO_WRITE_EN.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MDU_HILO_WRITE_EN
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    mdu_state_e         state_q;
    logic [3:0]         op_q;
    logic               sa_q;
    logic               sb_q;
    logic               dz_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH:0]     rem_q;
    logic               busy_q;
    logic               done_q;
    logic               div_zero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    assign a_neg = is_signed_op(op) & a[WIDTH-1];
    assign b_neg = is_signed_op(op) & b[WIDTH-1];

    mdu_sign_fix #(.DATA_W(WIDTH)) u_a_mag (
        .val_i (a),
        .neg_i (a_neg),
        .res_o (a_mag)
    );

    mdu_sign_fix #(.DATA_W(WIDTH)) u_b_mag (
        .val_i (b),
        .neg_i (b_neg),
        .res_o (b_mag)
    );

    // acc_q low half holds the multiplier (mul) or the shifting dividend/quotient (div).
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH:0]     div_rem_d;
    logic [2*WIDTH-1:0] div_acc_d;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh    = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        div_diff  = {1'b0, rem_sh} - {2'b00, mcand_q};
        div_rem_d = div_diff[WIDTH+1] ? rem_sh : div_diff[WIDTH:0];
        div_acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
    end

    logic               q_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign q_neg = sa_q ^ sb_q;

    mdu_sign_fix #(.DATA_W(2*WIDTH)) u_prod_fix (
        .val_i (acc_q),
        .neg_i (q_neg),
        .res_o (prod_fix)
    );

    mdu_sign_fix #(.DATA_W(WIDTH)) u_quo_fix (
        .val_i (acc_q[WIDTH-1:0]),
        .neg_i (q_neg),
        .res_o (quo_fix)
    );

    // Remainder follows the dividend sign, which also rebuilds the raw dividend on divide-by-zero.
    mdu_sign_fix #(.DATA_W(WIDTH)) u_rem_fix (
        .val_i (rem_q[WIDTH-1:0]),
        .neg_i (sa_q),
        .res_o (rem_fix)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            dz_q       <= 1'b0;
            cnt_q      <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && is_mdu_op(op)) begin
                        state_q    <= ST_CALC;
                        busy_q     <= 1'b1;
                        op_q       <= op;
                        sa_q       <= a_neg;
                        sb_q       <= b_neg;
                        dz_q       <= is_div_op(op) && (b == '0);
                        div_zero_q <= 1'b0;
                        cnt_q      <= CNT_W'(WIDTH - 1);
                        mcand_q    <= b_mag;
                        acc_q      <= {{WIDTH{1'b0}}, a_mag};
                        rem_q      <= '0;
                    end
`ifdef MDU_HILO_WRITE_EN
                    if (hilo_we[1]) begin
                        hi_q <= hilo_wdata;
                    end
                    if (hilo_we[0]) begin
                        lo_q <= hilo_wdata;
                    end
`endif
                end
                ST_CALC: begin
                    if (is_div_op(op_q)) begin
                        acc_q <= div_acc_d;
                        rem_q <= div_rem_d;
                    end else begin
                        acc_q <= mul_acc_d;
                    end
                    if (cnt_q == '0) begin
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    if (is_div_op(op_q)) begin
                        lo_q       <= dz_q ? {WIDTH{1'b1}} : quo_fix;
                        hi_q       <= rem_fix;
                        div_zero_q <= dz_q;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized and directed bench for mdu_iter, running a 32-bit and an 8-bit
// instance side by side against an arithmetic reference model.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W1   = 32;
    localparam int W2   = 8;
    localparam int NWIN = W1 + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          start1, start2;
    logic [3:0]    op;
    logic [W1-1:0] a1, b1, hi1, lo1;
    logic [W2-1:0] a2, b2, hi2, lo2;
    logic          busy1, done1, dz1, busy2, done2, dz2;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_hi1 = '0, exp_lo1 = '0, exp_hi2 = '0, exp_lo2 = '0;

    mdu_iter #(.WIDTH(W1)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .start(start1), .op(op), .a(a1), .b(b1),
`ifdef MDU_HILO_WRITE_EN
        .hilo_we(2'b00), .hilo_wdata('0),
`endif
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1), .div_zero(dz1)
    );

    mdu_iter #(.WIDTH(W2)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start2), .op(op), .a(a2), .b(b2),
`ifdef MDU_HILO_WRITE_EN
        .hilo_we(2'b00), .hilo_wdata('0),
`endif
        .busy(busy2), .done(done2), .hi(hi2), .lo(lo2), .div_zero(dz2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic void model(input int w, input logic [3:0] o, input logic [63:0] x, y,
                                  output logic [63:0] h, output logic [63:0] l, output logic z);
        logic [63:0] m, ux, uy, p;
        longint sx, sy, sp;
        m  = (64'd1 << w) - 64'd1;
        ux = x & m;
        uy = y & m;
        sx = $signed(ux << (64 - w)) >>> (64 - w);
        sy = $signed(uy << (64 - w)) >>> (64 - w);
        h = '0; l = '0; z = 1'b0;
        case (o)
            MDU_MULU: begin p = ux * uy; l = p & m; h = (p >> w) & m; end
            MDU_MUL:  begin sp = sx * sy; p = 64'(sp); l = p & m; h = (p >> w) & m; end
            MDU_DIVU: begin
                if (uy == 0) begin l = m; h = ux; z = 1'b1; end
                else begin l = ux / uy; h = ux % uy; end
            end
            MDU_DIV: begin
                if (uy == 0) begin l = m; h = ux; z = 1'b1; end
                else begin
                    sp = sx / sy; l = 64'(sp) & m;
                    sp = sx % sy; h = 64'(sp) & m;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic verify(input int w, input logic [3:0] o, input logic [63:0] x, y, hc, lc,
                          input logic zc, zs, input int dcyc, dcnt, bcnt);
        logic [63:0] eh, el;
        logic ez;
        string t;
        model(w, o, x, y, eh, el, ez);
        t = $sformatf("w%0d op%0h a%0h b%0h", w, o, x, y);
        check({t, " hi"}, hc, eh);
        check({t, " lo"}, lc, el);
        check({t, " div_zero"}, 64'(zc), 64'(ez));
        check({t, " dz_clear_at_start"}, 64'(zs), 64'd0);
        check({t, " done_cycle"}, 64'(dcyc), 64'(w + 2));
        check({t, " done_count"}, 64'(dcnt), 64'd1);
        check({t, " busy_cycles"}, 64'(bcnt), 64'(w + 2));
        if (w == W1) begin exp_hi1 = eh; exp_lo1 = el; end
        else begin exp_hi2 = eh; exp_lo2 = el; end
    endtask

    task automatic run_op(input logic [3:0] o, input logic [63:0] x1, y1, x2, y2, input bit poke);
        int dcyc1, dcyc2, dcnt1, dcnt2, bcnt1, bcnt2;
        logic zs1, zs2, zc1, zc2;
        logic [63:0] hc1, lc1, hc2, lc2;
        dcyc1 = -1; dcyc2 = -1; dcnt1 = 0; dcnt2 = 0; bcnt1 = 0; bcnt2 = 0;
        hc1 = '0; lc1 = '0; hc2 = '0; lc2 = '0; zs1 = 1'b0; zs2 = 1'b0; zc1 = 1'b0; zc2 = 1'b0;
        @(negedge clk);
        op = o; a1 = x1[W1-1:0]; b1 = y1[W1-1:0]; a2 = x2[W2-1:0]; b2 = y2[W2-1:0];
        start1 = 1'b1; start2 = 1'b1;
        for (int n = 1; n <= NWIN; n++) begin
            @(negedge clk);
            start1 = 1'b0; start2 = 1'b0;
            if (n == 1) begin
                zs1 = dz1; zs2 = dz2;
                op = 4'($urandom_range(3, 6)); a1 = $urandom; b1 = $urandom;
                a2 = 8'($urandom); b2 = 8'($urandom);
            end
            if (busy1) bcnt1++;
            if (busy2) bcnt2++;
            if (done1) begin
                dcnt1++;
                if (dcyc1 < 0) begin dcyc1 = n; hc1 = 64'(hi1); lc1 = 64'(lo1); end
            end
            if (done2) begin
                dcnt2++;
                if (dcyc2 < 0) begin dcyc2 = n; hc2 = 64'(hi2); lc2 = 64'(lo2); end
            end
            if (n == NWIN) begin zc1 = dz1; zc2 = dz2; end
            if (poke && (n == 5 || n == W1 + 2)) start1 = 1'b1;
            if (poke && (n == 5 || n == W2 + 2)) start2 = 1'b1;
        end
        start1 = 1'b0; start2 = 1'b0;
        verify(W1, o, x1, y1, hc1, lc1, zc1, zs1, dcyc1, dcnt1, bcnt1);
        verify(W2, o, x2, y2, hc2, lc2, zc2, zs2, dcyc2, dcnt2, bcnt2);
    endtask

    task automatic illegal_op();
        int bsum, dsum;
        bsum = 0; dsum = 0;
        @(negedge clk);
        op = 4'b1000; a1 = $urandom; b1 = $urandom; a2 = 8'($urandom); b2 = 8'($urandom);
        start1 = 1'b1; start2 = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            start1 = 1'b0; start2 = 1'b0;
            bsum += int'(busy1) + int'(busy2);
            dsum += int'(done1) + int'(done2);
        end
        check("illegal busy", 64'(bsum), 64'd0);
        check("illegal done", 64'(dsum), 64'd0);
        check("illegal hi32", 64'(hi1), exp_hi1);
        check("illegal lo32", 64'(lo1), exp_lo1);
        check("illegal hi8", 64'(hi2), exp_hi2);
        check("illegal lo8", 64'(lo2), exp_lo2);
    endtask

    task automatic check_cleared(input string t);
        check({t, " busy32"}, 64'(busy1), 64'd0);
        check({t, " done32"}, 64'(done1), 64'd0);
        check({t, " hi32"}, 64'(hi1), 64'd0);
        check({t, " lo32"}, 64'(lo1), 64'd0);
        check({t, " dz32"}, 64'(dz1), 64'd0);
        check({t, " busy8"}, 64'(busy2), 64'd0);
        check({t, " done8"}, 64'(done2), 64'd0);
        check({t, " hi8"}, 64'(hi2), 64'd0);
        check({t, " lo8"}, 64'(lo2), 64'd0);
        check({t, " dz8"}, 64'(dz2), 64'd0);
        exp_hi1 = '0; exp_lo1 = '0; exp_hi2 = '0; exp_lo2 = '0;
    endtask

    task automatic reset_idle();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk);
        check_cleared("reset idle");
        reset_n = 1'b1;
    endtask

    task automatic reset_mid();
        int dsum;
        dsum = 0;
        @(negedge clk);
        op = MDU_DIV; a1 = $urandom; b1 = 32'd3; a2 = 8'($urandom); b2 = 8'd3;
        start1 = 1'b1; start2 = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start1 = 1'b0; start2 = 1'b0;
        end
        check("mid-op busy32 before reset", 64'(busy1), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_cleared("reset mid-op");
        reset_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            dsum += int'(done1) + int'(done2);
        end
        check("no done after abort", 64'(dsum), 64'd0);
    endtask

    initial begin
        logic [3:0] o;
        logic [63:0] x1, y1, x2, y2;
        reset_n = 1'b0; start1 = 1'b0; start2 = 1'b0; op = 4'b0000;
        a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        repeat (3) @(negedge clk);
        check_cleared("power-on reset");
        reset_n = 1'b1;

        run_op(MDU_MULU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFF, 64'hFF, 1'b0);
        run_op(MDU_MUL,  64'hFFFF_FFF9, 64'd3,         64'hF9, 64'd3, 1'b0);
        run_op(MDU_DIV,  64'hFFFF_FFF9, 64'd2,         64'hF9, 64'd2, 1'b0);
        run_op(MDU_DIVU, 64'd100,       64'd0,         64'd100, 64'd0, 1'b0);
        run_op(MDU_MULU, 64'd5,         64'd6,         64'd5, 64'd6, 1'b1);
        run_op(MDU_DIV,  64'h8000_0000, 64'hFFFF_FFFF, 64'h80, 64'hFF, 1'b0);
        run_op(MDU_DIV,  64'hFFFF_FFFB, 64'd0,         64'hFB, 64'd0, 1'b1);
        illegal_op();

        for (int i = 0; i < 30; i++) begin
            o  = 4'($urandom_range(3, 6));
            x1 = 64'($urandom); y1 = 64'($urandom);
            x2 = 64'($urandom_range(0, 255)); y2 = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin y1 = '0; y2 = '0; end
            if ($urandom_range(0, 7) == 0) begin x1 = 64'h8000_0000; x2 = 64'h80; end
            if ($urandom_range(0, 7) == 0) begin y1 = 64'hFFFF_FFFF; y2 = 64'hFF; end
            run_op(o, x1, y1, x2, y2, i[0]);
        end

        run_op(MDU_DIVU, 64'd77, 64'd0, 64'd77, 64'd0, 1'b0);
        reset_idle();
        reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
